rule_unpacker: RTL and testbench

Consumes the packed rule-ID stream produced by the port-group stage. Each beat is 128 bits holding 8 lanes of 16-bit rule IDs; 0 marks an empty lane. The block serialises the non-zero lanes into one rule ID per cycle for the downstream non-fast-pattern matcher. It always emits an end-of-packet indication, including for packets that matched no rules.

---
 rtl/rule_unpacker_pkg.sv | 29 ++
 rtl/rule_unpacker_if.sv | 33 +++
 rtl/rule_unpacker_lane_prio_enc.sv | 29 ++
 rtl/rule_unpacker.sv | 126 ++++++++++++
 tb/tb_rule_unpacker.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rule_unpacker_pkg.sv
// Shared widths, types and helpers for the rule-ID unpacker.
package rule_unpacker_pkg;

  localparam int unsigned LANES   = 8;
  localparam int unsigned LANE_W  = 16;
  localparam int unsigned DWIDTH  = LANES * LANE_W;
  localparam int unsigned IDX_W   = $clog2(LANES);
  localparam int unsigned EMPTY_W = 4;
  localparam int unsigned CNT_W   = 32;

  typedef logic [LANE_W-1:0] rule_id_t;

  // Lane 0 occupies the least significant LANE_W bits.
  typedef logic [LANES-1:0][LANE_W-1:0] beat_t;

  // An empty lane and the no-match terminator share this value.
  localparam rule_id_t RULE_TERM = '0;

  // One bit per lane that carries a real rule ID.
  function automatic logic [LANES-1:0] lane_mask(input beat_t beat);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      m[i] = (beat[i] != RULE_TERM);
    end
    return m;
  endfunction

endpackage

// File: rtl/rule_unpacker_if.sv
// Beat-in / rule-out stream bundle for the rule unpacker.
interface rule_unpacker_if;
  import rule_unpacker_pkg::*;

  logic [DWIDTH-1:0]  in_usr_data;
  logic               in_usr_valid;
  logic               in_usr_sop;
  logic               in_usr_eop;
  logic [EMPTY_W-1:0] in_usr_empty;
  logic               in_usr_ready;

  rule_id_t           out_rule_id;
  logic               out_rule_valid;
  logic               out_rule_last;
  logic               out_rule_ready;

  // Environment side: drives beats upstream, sinks rules downstream.
  modport master (
    output in_usr_data, in_usr_valid, in_usr_sop, in_usr_eop, in_usr_empty,
    output out_rule_ready,
    input  in_usr_ready,
    input  out_rule_id, out_rule_valid, out_rule_last
  );

  // Unpacker side.
  modport slave (
    input  in_usr_data, in_usr_valid, in_usr_sop, in_usr_eop, in_usr_empty,
    input  out_rule_ready,
    output in_usr_ready,
    output out_rule_id, out_rule_valid, out_rule_last
  );

endinterface

// File: rtl/rule_unpacker_lane_prio_enc.sv
// Lowest-set-bit encoder over the pending-lane mask.
module lane_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]                      mask_i,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
  output logic [N-1:0]                      onehot_o,
  output logic                              single_o,
  output logic                              any_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

  assign onehot_o = mask_i & (~mask_i + N'(1));
  // True when zero or one lane remains, i.e. the current emit is the beat's final one.
  assign single_o = ((mask_i & (mask_i - N'(1))) == '0);
  assign any_o    = |mask_i;

endmodule

// File: rtl/rule_unpacker.sv
// Serialises the non-zero lanes of each packed rule beat, one rule ID per cycle.
module rule_unpacker
  import rule_unpacker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rule_unpacker_if.slave    bus,
  output logic [CNT_W-1:0]  rule_cnt,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              proto_err
);

  beat_t            data_q, data_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic             buf_valid_q, buf_valid_d;
  logic             buf_eop_q, buf_eop_d;
  logic             in_pkt_q, in_pkt_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] rule_cnt_q, rule_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [IDX_W-1:0] idx_c;
  logic [LANES-1:0] onehot_c;
  logic             single_c;
  logic             any_c;
  logic [LANES-1:0] in_mask_c;
  logic             term_c;
  rule_id_t         id_c;
  logic             last_c;
  logic             accept_c;
  logic             out_hs_c;
  logic             empty_unused_c;

  lane_prio_enc #(.N(LANES)) u_enc (
    .mask_i   (mask_q),
    .idx_o    (idx_c),
    .onehot_o (onehot_c),
    .single_o (single_c),
    .any_o    (any_c)
  );

  // Upstream always sends zero here; fold it away so it is visibly consumed.
  assign empty_unused_c = ^bus.in_usr_empty;

  // A held beat with no pending lanes can only be a no-match terminator.
  assign term_c    = buf_valid_q & ~any_c;
  assign id_c      = (buf_valid_q & ~term_c) ? data_q[idx_c] : RULE_TERM;
  assign last_c    = buf_valid_q & buf_eop_q & single_c;
  assign in_mask_c = lane_mask(bus.in_usr_data);
  assign accept_c  = bus.in_usr_valid & ~buf_valid_q;
  assign out_hs_c  = buf_valid_q & bus.out_rule_ready;

  assign bus.in_usr_ready   = ~buf_valid_q;
  assign bus.out_rule_valid = buf_valid_q;
  assign bus.out_rule_id    = id_c;
  assign bus.out_rule_last  = last_c;
  assign rule_cnt           = rule_cnt_q;
  assign pkt_cnt            = pkt_cnt_q;
  assign proto_err          = proto_err_q;

  // Next state: drain one lane per handshake, reload only when the buffer is empty.
  always_comb begin
    data_d      = data_q;
    mask_d      = mask_q;
    buf_valid_d = buf_valid_q;
    buf_eop_d   = buf_eop_q;
    in_pkt_d    = in_pkt_q;
    proto_err_d = proto_err_q;
    rule_cnt_d  = rule_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (out_hs_c) begin
      mask_d = mask_q & ~onehot_c;
      if (single_c) begin
        buf_valid_d = 1'b0;
      end
      if (id_c != RULE_TERM) begin
        rule_cnt_d = rule_cnt_q + CNT_W'(1);
      end
      if (last_c) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end

    // Accept and handshake are exclusive: accept needs an empty buffer.
    if (accept_c) begin
      data_d      = bus.in_usr_data;
      mask_d      = in_mask_c;
      buf_eop_d   = bus.in_usr_eop;
      // An all-zero middle beat is dropped; an all-zero last beat becomes a terminator.
      buf_valid_d = (|in_mask_c) | bus.in_usr_eop;
      if (bus.in_usr_sop == in_pkt_q) begin
        proto_err_d = 1'b1;
      end
      if (bus.in_usr_eop) begin
        in_pkt_d = 1'b0;
      end else if (bus.in_usr_sop) begin
        in_pkt_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any partially drained beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      mask_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_eop_q   <= 1'b0;
      in_pkt_q    <= 1'b0;
      proto_err_q <= 1'b0;
      rule_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      data_q      <= data_d;
      mask_q      <= mask_d;
      buf_valid_q <= buf_valid_d;
      buf_eop_q   <= buf_eop_d;
      in_pkt_q    <= in_pkt_d;
      proto_err_q <= proto_err_d;
      rule_cnt_q  <= rule_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_rule_unpacker.sv
// Scoreboard bench for rule_unpacker: directed scenarios plus random packets.
module tb_rule_unpacker;
  import rule_unpacker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rule_unpacker_if bus();
  logic [CNT_W-1:0] rule_cnt;
  logic [CNT_W-1:0] pkt_cnt;
  logic             proto_err;

  rule_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rule_cnt  (rule_cnt),
    .pkt_cnt   (pkt_cnt),
    .proto_err (proto_err)
  );

  typedef struct packed {
    rule_id_t id;
    logic     last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model state
  int   m_rule   = 0;
  int   m_pkt    = 0;
  bit   m_err    = 0;
  bit   m_in_pkt = 0;

  // Downstream ready control: 0 always ready, 1 random, 2 pattern queue
  int   rdy_mode = 0;
  bit   pat_q[$];

  bit   gap_valid    = 0;
  int   last_acc_cyc = 0;
  int   prev_cost    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural model: expected emissions, beat occupancy and framing for one accepted beat.
  task automatic model_beat(input logic [DWIDTH-1:0] d, input bit sop, input bit eop,
                            output int cost);
    rule_id_t nz[$];
    rule_id_t v;
    for (int i = 0; i < int'(LANES); i++) begin
      v = d[i*LANE_W +: LANE_W];
      if (v != 0) nz.push_back(v);
    end
    for (int j = 0; j < nz.size(); j++)
      exp_q.push_back('{id: nz[j], last: (eop && (j == nz.size() - 1))});
    if (nz.size() == 0 && eop) exp_q.push_back('{id: '0, last: 1'b1});
    if (nz.size() > 0) cost = nz.size() + 1;
    else               cost = eop ? 2 : 1;
    if ((sop && m_in_pkt) || (!sop && !m_in_pkt)) m_err = 1;
    if (eop)      m_in_pkt = 0;
    else if (sop) m_in_pkt = 1;
  endtask

  // Offer one beat; called and returns at posedge+1.
  task automatic send_beat(input logic [DWIDTH-1:0] d, input bit sop, input bit eop,
                           input bit chk_gap);
    int waited;
    int cost;
    bus.in_usr_data  = d;
    bus.in_usr_sop   = sop;
    bus.in_usr_eop   = eop;
    bus.in_usr_empty = '0;
    bus.in_usr_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_usr_ready && waited < 300);
    if (!bus.in_usr_ready) begin
      check("in_usr_ready_timeout", 64'(bus.in_usr_ready), 64'd1);
      bus.in_usr_valid = 1'b0;
      return;
    end
    if (chk_gap && gap_valid) check("accept_gap_cycles", 64'(cyc - last_acc_cyc), 64'(prev_cost));
    model_beat(d, sop, eop, cost);
    gap_valid    = 1;
    last_acc_cyc = cyc;
    prev_cost    = cost;
    @(posedge clk);
    #1;
    bus.in_usr_valid = 1'b0;
    bus.in_usr_sop   = 1'b0;
    bus.in_usr_eop   = 1'b0;
    check("proto_err", 64'(proto_err), 64'(m_err));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("idle_out_valid", 64'(bus.out_rule_valid), 64'd0);
  endtask

  function automatic logic [DWIDTH-1:0] mk_beat(input int l0, input int l1, input int l2,
                                                input int l3, input int l4, input int l5,
                                                input int l6, input int l7);
    logic [DWIDTH-1:0] d;
    d = {LANE_W'(l7), LANE_W'(l6), LANE_W'(l5), LANE_W'(l4),
         LANE_W'(l3), LANE_W'(l2), LANE_W'(l1), LANE_W'(l0)};
    return d;
  endfunction

  // Downstream ready driver
  initial begin
    bus.out_rule_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_rule_ready = 1'b1;
        1:       bus.out_rule_ready = ($urandom_range(0, 9) < 7);
        default: bus.out_rule_ready = (pat_q.size() != 0) ? pat_q.pop_front() : 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stalls hold.
  initial begin
    bit       stall_prev = 0;
    bit       cnt_pend   = 0;
    rule_id_t prev_id    = '0;
    logic     prev_last  = 1'b0;
    exp_t     e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        stall_prev = 0;
        cnt_pend   = 0;
      end else begin
        if (cnt_pend) begin
          check("rule_cnt", 64'(rule_cnt), 64'(m_rule));
          check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
          cnt_pend = 0;
        end
        if (stall_prev) begin
          check("stall_hold_valid", 64'(bus.out_rule_valid), 64'd1);
          check("stall_hold_id", 64'(bus.out_rule_id), 64'(prev_id));
          check("stall_hold_last", 64'(bus.out_rule_last), 64'(prev_last));
        end
        if (bus.out_rule_valid && bus.out_rule_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 64'(bus.out_rule_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_rule_id", 64'(bus.out_rule_id), 64'(e.id));
            check("out_rule_last", 64'(bus.out_rule_last), 64'(e.last));
            if (e.id != 0) m_rule++;
            if (e.last)    m_pkt++;
            cnt_pend = 1;
          end
        end
        stall_prev = bus.out_rule_valid && !bus.out_rule_ready;
        prev_id    = bus.out_rule_id;
        prev_last  = bus.out_rule_last;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_rule_valid), 64'd0);
    check({tag, "_out_id"}, 64'(bus.out_rule_id), 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_rule_last), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_usr_ready), 64'd1);
    check({tag, "_rule_cnt"}, 64'(rule_cnt), 64'd0);
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
    check({tag, "_proto_err"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    logic [DWIDTH-1:0] d;
    int nb;
    bus.in_usr_data  = '0;
    bus.in_usr_valid = 1'b0;
    bus.in_usr_sop   = 1'b0;
    bus.in_usr_eop   = 1'b0;
    bus.in_usr_empty = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Sparse beat, terminator packet, then a 3-beat packet with a dropped middle beat
    rdy_mode = 0;
    send_beat(mk_beat(0, 16'h0005, 0, 16'h0123, 0, 0, 0, 16'h1FFF), 1, 1, 0);
    send_beat(mk_beat(0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1);
    send_beat(mk_beat(7, 8, 0, 0, 0, 0, 0, 0), 1, 0, 1);
    send_beat(mk_beat(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1);
    send_beat(mk_beat(0, 0, 0, 0, 0, 9, 0, 0), 0, 1, 1);
    wait_drain();

    // Sparse beat under a stall pattern
    rdy_mode = 2;
    pat_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    send_beat(mk_beat(0, 16'h0005, 0, 16'h0123, 0, 0, 0, 16'h1FFF), 1, 1, 0);
    wait_drain();

    // Two back-to-back full packets
    rdy_mode = 0;
    send_beat(mk_beat(1, 2, 3, 4, 5, 6, 7, 8), 1, 1, 0);
    send_beat(mk_beat(9, 10, 11, 12, 13, 14, 15, 16), 1, 1, 1);
    send_beat(mk_beat(0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1);
    wait_drain();

    // Framing error, then reset in the middle of draining a full beat
    send_beat(mk_beat(16'h11, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0);
    send_beat(mk_beat(16'h22, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0);
    send_beat(mk_beat(1, 2, 3, 4, 5, 6, 7, 8), 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("proto_err_sticky", 64'(proto_err), 64'd1);
    check("mid_drain_valid", 64'(bus.out_rule_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_state("mid_reset");
    exp_q.delete();
    m_rule = 0; m_pkt = 0; m_err = 0; m_in_pkt = 0; gap_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_valid", 64'(bus.out_rule_valid), 64'd0);
    send_beat(mk_beat(0, 16'h0005, 0, 16'h0123, 0, 0, 0, 16'h1FFF), 1, 1, 0);
    wait_drain();

    // Random well-framed packets with random backpressure
    for (int p = 0; p < 40; p++) begin
      rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        d = '0;
        if ($urandom_range(0, 5) != 0) begin
          for (int i = 0; i < int'(LANES); i++)
            if ($urandom_range(0, 2) != 0) d[i*LANE_W +: LANE_W] = LANE_W'($urandom_range(1, 65535));
        end
        send_beat(d, (b == 0), (b == nb - 1), 0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rdy_mode = 1;
    wait_drain();
    check("final_rule_cnt", 64'(rule_cnt), 64'(m_rule));
    check("final_pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    check("final_proto_err", 64'(proto_err), 64'(m_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
